// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and widths for the architectural register file and its ROB-id scoreboard.
package regfile_scoreboard_pkg;

    localparam int REG_FILE_DATA_W = 32;
    localparam int REG_FILE_ADDR_W = 5;
    localparam int ROB_ID_W        = 4;

    typedef enum logic [2:0] {
        XCPT_NONE        = 3'd0,
        XCPT_ILLEGAL     = 3'd1,
        XCPT_LOAD_FAULT  = 3'd2,
        XCPT_STORE_FAULT = 3'd3,
        XCPT_MISALIGN    = 3'd4,
        XCPT_SYSCALL     = 3'd5
    } xcpt_type_t;

endpackage

// File: rtl/regfile_scoreboard_entry.sv
// One architectural register: data, pending bit and producer ROB id.
// Flush beats alloc, and alloc beats a matching retirement write.
module regfile_scoreboard_entry
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = REG_FILE_DATA_W,
    parameter int ID_W   = ROB_ID_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_hit,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ID_W-1:0]   wr_id,
    input  logic              alloc_hit,
    input  logic [ID_W-1:0]   alloc_id,
    input  logic              flush,
    output logic [DATA_W-1:0] data,
    output logic              pending,
    output logic [ID_W-1:0]   owner,
    output logic              byp_pending
);

    logic wr_match;

    assign wr_match    = wr_hit && (owner == wr_id);
    // Read-side view of pending after a same-cycle write; alloc is not seen by reads.
    assign byp_pending = pending && !(wr_match && !alloc_hit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data    <= '0;
            pending <= 1'b0;
            owner   <= '0;
        end else begin
            if (wr_hit)
                data <= wr_data;
            if (flush) begin
                pending <= 1'b0;
            end else if (alloc_hit) begin
                pending <= 1'b1;
                owner   <= alloc_id;
            end else if (wr_match) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register ROB-id scoreboard and exception capture.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = REG_FILE_DATA_W,
    parameter int ADDR_W   = REG_FILE_ADDR_W,
    parameter int ID_W     = ROB_ID_W,
    parameter int PC_W     = 32,
    parameter int XADDR_W  = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               alloc_valid,
    input  logic [ADDR_W-1:0]  alloc_dest,
    input  logic [ID_W-1:0]    alloc_instr_id,
    input  logic [ADDR_W-1:0]  src1_addr,
    input  logic [ADDR_W-1:0]  src2_addr,
    output logic [DATA_W-1:0]  src1_data,
    output logic [DATA_W-1:0]  src2_data,
    output logic               src1_pending,
    output logic               src2_pending,
    output logic [ID_W-1:0]    src1_id,
    output logic [ID_W-1:0]    src2_id,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic [ADDR_W-1:0]  wr_dest,
    input  logic [ID_W-1:0]    wr_instr_id,
    input  logic               xcpt_valid,
    input  xcpt_type_t         xcpt_type,
    input  logic [PC_W-1:0]    xcpt_pc,
    input  logic [XADDR_W-1:0] xcpt_addr,
    output logic [PC_W-1:0]    rm0_pc,
    output logic [XADDR_W-1:0] rm1_addr,
    output xcpt_type_t         rm2_type,
    output logic               rm_valid,
    input  logic               rm_clear,
    output logic               any_pending
);

    logic [NUM_REGS-1:0][DATA_W-1:0] data_q;
    logic [NUM_REGS-1:0][ID_W-1:0]   owner_q;
    logic [NUM_REGS-1:0]             pend_q;
    logic [NUM_REGS-1:0]             byp_pend;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        regfile_scoreboard_entry #(.DATA_W(DATA_W), .ID_W(ID_W)) u_entry (
            .clock       (clock),
            .reset       (reset),
            .wr_hit      (wr_en && (wr_dest == ADDR_W'(i))),
            .wr_data     (wr_data),
            .wr_id       (wr_instr_id),
            .alloc_hit   (alloc_valid && !xcpt_valid && (alloc_dest == ADDR_W'(i))),
            .alloc_id    (alloc_instr_id),
            .flush       (xcpt_valid),
            .data        (data_q[i]),
            .pending     (pend_q[i]),
            .owner       (owner_q[i]),
            .byp_pending (byp_pend[i])
        );
    end

    assign src1_data    = (wr_en && wr_dest == src1_addr) ? wr_data : data_q[src1_addr];
    assign src2_data    = (wr_en && wr_dest == src2_addr) ? wr_data : data_q[src2_addr];
    assign src1_pending = byp_pend[src1_addr];
    assign src2_pending = byp_pend[src2_addr];
    assign src1_id      = owner_q[src1_addr];
    assign src2_id      = owner_q[src2_addr];
    assign any_pending  = |pend_q;

    // A new exception overwrites an unconsumed one and wins over rm_clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rm0_pc   <= '0;
            rm1_addr <= '0;
            rm2_type <= XCPT_NONE;
            rm_valid <= 1'b0;
        end else if (xcpt_valid) begin
            rm0_pc   <= xcpt_pc;
            rm1_addr <= xcpt_addr;
            rm2_type <= xcpt_type;
            rm_valid <= 1'b1;
        end else if (rm_clear) begin
            rm_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass, stale writes, alloc priority, exceptions, async reset.
module tb_regfile_scoreboard;
    import regfile_scoreboard_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        alloc_valid = 1'b0;
    logic [4:0]  alloc_dest = '0;
    logic [3:0]  alloc_instr_id = '0;
    logic [4:0]  src1_addr = '0, src2_addr = '0;
    logic [31:0] src1_data, src2_data;
    logic        src1_pending, src2_pending;
    logic [3:0]  src1_id, src2_id;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic [4:0]  wr_dest = '0;
    logic [3:0]  wr_instr_id = '0;
    logic        xcpt_valid = 1'b0;
    xcpt_type_t  xcpt_type = XCPT_NONE;
    logic [31:0] xcpt_pc = '0, xcpt_addr = '0;
    logic [31:0] rm0_pc, rm1_addr;
    xcpt_type_t  rm2_type;
    logic        rm_valid, rm_clear = 1'b0, any_pending;

    int n_chk = 0, n_fail = 0;

    regfile_scoreboard dut (
        .clock(clock), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_dest(alloc_dest), .alloc_instr_id(alloc_instr_id),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .src1_data(src1_data), .src2_data(src2_data),
        .src1_pending(src1_pending), .src2_pending(src2_pending),
        .src1_id(src1_id), .src2_id(src2_id),
        .wr_en(wr_en), .wr_data(wr_data), .wr_dest(wr_dest), .wr_instr_id(wr_instr_id),
        .xcpt_valid(xcpt_valid), .xcpt_type(xcpt_type), .xcpt_pc(xcpt_pc), .xcpt_addr(xcpt_addr),
        .rm0_pc(rm0_pc), .rm1_addr(rm1_addr), .rm2_type(rm2_type), .rm_valid(rm_valid),
        .rm_clear(rm_clear), .any_pending(any_pending)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic alloc(input logic [4:0] d, input logic [3:0] id);
        alloc_valid = 1'b1; alloc_dest = d; alloc_instr_id = id;
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic set_wr(input logic [4:0] d, input logic [31:0] v, input logic [3:0] id);
        wr_en = 1'b1; wr_dest = d; wr_data = v; wr_instr_id = id;
    endtask

    initial begin
        #23 reset = 1'b0;
        tick();

        // reset state
        src1_addr = 5'd3; #1;
        chk("rst_data", src1_data, 0);
        chk("rst_pend", src1_pending, 0);
        chk("rst_any", any_pending, 0);
        chk("rst_rmv", rm_valid, 0);

        // alloc then matching write with bypass
        alloc(5'd5, 4'd7);
        src1_addr = 5'd5; #1;
        chk("al_pend", src1_pending, 1);
        chk("al_id", src1_id, 7);
        chk("al_any", any_pending, 1);
        set_wr(5'd5, 32'hDEADBEEF, 4'd7); #1;
        chk("byp_data", src1_data, 32'hDEADBEEF);
        chk("byp_pend", src1_pending, 0);
        tick(); wr_en = 1'b0; #1;
        chk("st_data", src1_data, 32'hDEADBEEF);
        chk("st_pend", src1_pending, 0);
        chk("st_any", any_pending, 0);

        // stale write leaves newer owner pending
        alloc(5'd5, 4'd7);
        alloc(5'd5, 4'd9);
        set_wr(5'd5, 32'h11, 4'd7); #1;
        chk("stale_byp_pend", src1_pending, 1);
        tick(); wr_en = 1'b0; #1;
        chk("stale_data", src1_data, 32'h11);
        chk("stale_pend", src1_pending, 1);
        chk("stale_id", src1_id, 9);
        set_wr(5'd5, 32'h33, 4'd9);
        tick(); wr_en = 1'b0; #1;
        chk("own_pend", src1_pending, 0);
        chk("own_data", src1_data, 32'h33);

        // same-cycle alloc and matching write: alloc wins, reads see pre-alloc owner
        alloc(5'd2, 4'd1);
        src2_addr = 5'd2;
        alloc_valid = 1'b1; alloc_dest = 5'd2; alloc_instr_id = 4'd4;
        set_wr(5'd2, 32'h22, 4'd1); #1;
        chk("aw_byp_data", src2_data, 32'h22);
        chk("aw_byp_pend", src2_pending, 1);
        chk("aw_byp_id", src2_id, 1);
        tick(); alloc_valid = 1'b0; wr_en = 1'b0; #1;
        chk("aw_data", src2_data, 32'h22);
        chk("aw_pend", src2_pending, 1);
        chk("aw_id", src2_id, 4);

        // exception: flush, capture, ignore alloc, keep write
        alloc(5'd1, 4'd2);
        alloc(5'd8, 4'd3);
        chk("pre_x_any", any_pending, 1);
        xcpt_valid = 1'b1; xcpt_pc = 32'h1000; xcpt_addr = 32'h2004; xcpt_type = XCPT_LOAD_FAULT;
        alloc_valid = 1'b1; alloc_dest = 5'd9; alloc_instr_id = 4'd5;
        set_wr(5'd6, 32'h66, 4'd0);
        tick();
        xcpt_valid = 1'b0; alloc_valid = 1'b0; wr_en = 1'b0;
        src1_addr = 5'd9; src2_addr = 5'd6; #1;
        chk("x_rm0", rm0_pc, 32'h1000);
        chk("x_rm1", rm1_addr, 32'h2004);
        chk("x_rm2", rm2_type, 2);
        chk("x_rmv", rm_valid, 1);
        chk("x_any", any_pending, 0);
        chk("x_r9_pend", src1_pending, 0);
        chk("x_wr_data", src2_data, 32'h66);
        rm_clear = 1'b1;
        tick(); rm_clear = 1'b0; #1;
        chk("clr_rmv", rm_valid, 0);

        // exception beats rm_clear, overwrites capture
        xcpt_valid = 1'b1; rm_clear = 1'b1; xcpt_pc = 32'h3000; xcpt_type = XCPT_ILLEGAL;
        tick(); xcpt_valid = 1'b0; rm_clear = 1'b0; #1;
        chk("xc_rmv", rm_valid, 1);
        chk("xc_rm0", rm0_pc, 32'h3000);
        chk("xc_rm2", rm2_type, 1);

        // async reset mid-cycle with r4 pending and rm_valid set
        alloc(5'd4, 4'd6);
        src1_addr = 5'd4; #1;
        chk("pre_rst_pend", src1_pending, 1);
        chk("pre_rst_id", src1_id, 6);
        #1 reset = 1'b1;
        #1;
        chk("ar_pend", src1_pending, 0);
        chk("ar_id", src1_id, 0);
        chk("ar_data6", src2_data, 0);
        chk("ar_rmv", rm_valid, 0);
        chk("ar_rm0", rm0_pc, 0);
        chk("ar_rm1", rm1_addr, 0);
        chk("ar_rm2", rm2_type, 0);
        chk("ar_any", any_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
